// File: rtl/sample_pwm.sv
// Sample FIFO feeding a PWM generator, one sample per 2^WIDTH-tick period.
// Define SAMPLE_PWM_HOLD_EN to hold the last sample on underflow instead of midscale.
module sample_pwm #(
    parameter int WIDTH    = 8,
    parameter int FIFO_AW  = 4,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   sample_in,
    input  logic               sample_valid,
    input  logic               flag_clr,
    output logic               fifo_full,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               pwm_out,
    output logic               overflow,
    output logic               underflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0]  MID      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
    localparam logic [PW-1:0]     PRE_MAX  = PW'(PRESCALE - 1);
    localparam logic [FIFO_AW:0]  LVL_FULL = (FIFO_AW+1)'(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [PW-1:0]      presc;
    logic [WIDTH-1:0]   cnt;
    logic [WIDTH-1:0]   duty;
    logic               armed;

    logic tick;
    logic load;
    logic empty;
    logic wr_en;
    logic pop;

    assign fifo_full = (fifo_level == LVL_FULL);

    // Full/empty come from the registered level, so a pop never frees room for a same-cycle write.
    always_comb begin
        tick  = (presc == PRE_MAX);
        load  = tick && (cnt == CNT_MAX);
        empty = (fifo_level == '0);
        wr_en = sample_valid && !fifo_full;
        pop   = load && !empty;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            cnt        <= '0;
            duty       <= MID;
            armed      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            pwm_out    <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);

            if (tick)
                cnt <= cnt + WIDTH'(1);

            if (wr_en)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);

            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + (FIFO_AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (FIFO_AW+1)'(1);
                default: fifo_level <= fifo_level;
            endcase

            if (pop) begin
                duty  <= mem[rd_ptr];
                armed <= 1'b1;
            end else if (load) begin
`ifdef SAMPLE_PWM_HOLD_EN
                duty <= duty;
`else
                duty <= MID;
`endif
            end

            pwm_out <= (cnt < duty);

            overflow  <= (sample_valid && fifo_full) || (overflow && !flag_clr);
            underflow <= (load && empty && armed)    || (underflow && !flag_clr);
        end
    end

endmodule

// File: tb/tb_sample_pwm.sv
// Bench for sample_pwm: table-driven duty vectors, hand sequences and a random run
// against a queue-based reference model (PRESCALE=1), plus a PRESCALE=3 instance.
module tb_sample_pwm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SAMPLE_PWM_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       rst0 = 1'b1, v0 = 1'b0, clr0 = 1'b0;
    logic [7:0] s0 = '0;
    logic       full0, pwm0, ovf0, unf0;
    logic [4:0] lvl0;

    logic       rst3 = 1'b1, v3 = 1'b0, clr3 = 1'b0;
    logic [7:0] s3 = '0;
    logic       full3, pwm3, ovf3, unf3;
    logic [4:0] lvl3;

    sample_pwm #(.WIDTH(8), .FIFO_AW(4), .PRESCALE(1)) dut0 (
        .clk(clk), .rst(rst0), .sample_in(s0), .sample_valid(v0), .flag_clr(clr0),
        .fifo_full(full0), .fifo_level(lvl0), .pwm_out(pwm0),
        .overflow(ovf0), .underflow(unf0)
    );

    sample_pwm #(.WIDTH(8), .FIFO_AW(4), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst3), .sample_in(s3), .sample_valid(v3), .flag_clr(clr3),
        .fifo_full(full3), .fifo_level(lvl3), .pwm_out(pwm3),
        .overflow(ovf3), .underflow(unf3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: edges since reset, a sample queue, and the current duty.
    int         m_k;
    logic [7:0] m_q[$];
    int         m_duty;
    bit         m_armed, m_ovf, m_unf;
    int         hi0, hi3;

    task automatic model_reset();
        m_k = 0;
        m_q.delete();
        m_duty  = 128;
        m_armed = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic step(input bit v, input logic [7:0] s, input bit clr);
        int cnt_now;
        bit load, full, ov_set, un_set, pwm_exp;
        v0 = v; s0 = s; clr0 = clr;
        @(posedge clk);
        #1;
        cnt_now = m_k % 256;
        load    = (cnt_now == 255);
        full    = (m_q.size() == 16);
        pwm_exp = (cnt_now < m_duty);
        ov_set  = v && full;
        un_set  = load && (m_q.size() == 0) && m_armed;
        if (load) begin
            if (m_q.size() > 0) begin
                m_duty  = m_q.pop_front();
                m_armed = 1'b1;
            end else if (!HOLD) begin
                m_duty = 128;
            end
        end
        if (v && !full)
            m_q.push_back(s);
        m_ovf = ov_set || (m_ovf && !clr);
        m_unf = un_set || (m_unf && !clr);
        m_k++;
        check("pwm_out",    pwm0, pwm_exp);
        check("fifo_level", lvl0, m_q.size());
        check("fifo_full",  full0, m_q.size() == 16);
        check("overflow",   ovf0, m_ovf);
        check("underflow",  unf0, m_unf);
        hi0 += int'(pwm0);
        hi3 += int'(pwm3);
        @(negedge clk);
        v0 = 1'b0; clr0 = 1'b0; v3 = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_load();
        while (m_k % 256 != 0)
            step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic reset0();
        rst0 = 1'b1;
        #1;
        check("rst pwm_out",    pwm0, 0);
        check("rst fifo_level", lvl0, 0);
        check("rst fifo_full",  full0, 0);
        check("rst overflow",   ovf0, 0);
        check("rst underflow",  unf0, 0);
        @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [7:0] smp;
        int         high;
    } vec_t;
    vec_t vt[6];

    initial begin
        vt[0] = '{8'h40, 64};
        vt[1] = '{8'hC0, 192};
        vt[2] = '{8'h00, 0};
        vt[3] = '{8'hFF, 255};
        vt[4] = '{8'h01, 1};
        vt[5] = '{8'h80, 128};

        @(negedge clk);
        check("rst3 pwm_out",    pwm3, 0);
        check("rst3 fifo_level", lvl3, 0);
        check("rst3 underflow",  unf3, 0);
        reset0();

        // Idle after reset: midscale square wave, never armed.
        for (int p = 0; p < 3; p++) begin
            hi0 = 0;
            run(256);
            check("idle high", hi0, 128);
        end
        check("idle underflow", unf0, 0);

        for (int i = 0; i < 6; i++) begin
            step(1'b1, vt[i].smp, 1'b0);
            wait_load();
            hi0 = 0;
            run(256);
            check($sformatf("high duty %02h", vt[i].smp), hi0, vt[i].high);
        end

        // Two queued samples play in consecutive periods.
        step(1'b1, 8'h40, 1'b0);
        step(1'b1, 8'hC0, 1'b0);
        check("pair level", lvl0, 2);
        wait_load();
        hi0 = 0; run(256); check("pair high 1", hi0, 64);
        hi0 = 0; run(256); check("pair high 2", hi0, 192);
        check("pair drained", lvl0, 0);

        // Starvation after one sample.
        step(1'b0, 8'h00, 1'b1);
        check("clr underflow", unf0, 0);
        step(1'b1, 8'h20, 1'b0);
        wait_load();
        hi0 = 0; run(256); check("starve play", hi0, 32);
        check("starve underflow", unf0, 1);
        hi0 = 0; run(256); check("starve high", hi0, HOLD ? 32 : 128);
        step(1'b0, 8'h00, 1'b1);
        check("clr underflow 2", unf0, 0);

        // Overflow: 17 writes into a 16-deep FIFO, no load in between.
        reset0();
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 8'(i * 13), 1'b0);
            if (i == 16) begin
                check("full after 16", full0, 1);
                check("level after 16", lvl0, 16);
                check("no overflow at 16", ovf0, 0);
            end
        end
        check("overflow after 17", ovf0, 1);
        check("level after 17", lvl0, 16);

        // Randomised traffic against the model at several write rates.
        for (int c = 0; c < 20; c++) begin
            int rate;
            case ($urandom_range(3))
                0:       rate = 400;
                1:       rate = 150;
                2:       rate = 60;
                default: rate = 15;
            endcase
            for (int n = 0; n < 1000; n++)
                step($urandom_range(rate - 1) == 0, 8'($urandom), $urandom_range(99) == 0);
        end

        // PRESCALE=3: period 768 clocks, sample 0x10 high for 48 clocks.
        rst3 = 1'b0;
        v3 = 1'b1; s3 = 8'h10;
        hi3 = 0;
        run(768);
        check("p3 first period", hi3, 384);
        hi3 = 0;
        run(768);
        check("p3 sample period", hi3, 48);
        check("p3 underflow", unf3, 1);
        check("p3 drained", lvl3, 0);
        v3 = 1'b1; s3 = 8'h55;
        run(2);
        check("p3 pre-rst pwm", pwm3, 1);
        check("p3 pre-rst level", lvl3, 1);
        #2 rst3 = 1'b1;
        #1;
        check("p3 async pwm_out",    pwm3, 0);
        check("p3 async fifo_level", lvl3, 0);
        check("p3 async fifo_full",  full3, 0);
        check("p3 async overflow",   ovf3, 0);
        check("p3 async underflow",  unf3, 0);
        #1 rst3 = 1'b0;
        run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
